hsosc_pwr_seq: RTL and testbench

// - Drives the CLKHFPU / CLKHFEN pins of the iCE40UP high-speed oscillator from an always-on clock.
// - Enforces the 100 us power-up period with enable held low before the output is enabled.
// - Sequences the shutdown as enable low, then guard time, then power-up low.
// - Gives downstream logic a clean level handshake: hold req high, wait for ready.
// - Sits in the clock/reset tile, beside the HSOSC instance and the clock mux.
//

---
 rtl/hsosc_seq_pkg.sv | 51 +++++
 rtl/hsosc_pwr_seq_chk.sv | 46 ++++
 rtl/seq_timer.sv | 43 ++++
 rtl/hsosc_pwr_seq.sv | 124 ++++++++++++
 tb/tb_hsosc_pwr_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hsosc_seq_pkg.sv
// Shared definitions for the HF oscillator power sequencer: state codes,
// output bundle, and helpers for sizing the sequencing counter.
package hsosc_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_OFF       = 3'd0;
    localparam logic [STATE_W-1:0] ST_PU_WAIT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_EN_SETTLE = 3'd2;
    localparam logic [STATE_W-1:0] ST_ON        = 3'd3;
    localparam logic [STATE_W-1:0] ST_DISABLE   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_OFF       = ST_OFF,
        S_PU_WAIT   = ST_PU_WAIT,
        S_EN_SETTLE = ST_EN_SETTLE,
        S_ON        = ST_ON,
        S_DISABLE   = ST_DISABLE
    } seq_state_e;

    // Pin and handshake levels that belong to one state
    typedef struct packed {
        logic pu;
        logic en;
        logic rdy;
        logic busy;
    } seq_out_t;

    // Counter width large enough to hold the largest (N-1) load value
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        cnt_width = (m < 2) ? 1 : $clog2(m);
    endfunction

    // Output levels for each state; anything unknown is treated as fully off
    function automatic seq_out_t decode_state(input seq_state_e s);
        seq_out_t o;
        case (s)
            S_OFF:       o = '{pu: 1'b0, en: 1'b0, rdy: 1'b0, busy: 1'b0};
            S_PU_WAIT:   o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0, busy: 1'b1};
            S_EN_SETTLE: o = '{pu: 1'b1, en: 1'b1, rdy: 1'b0, busy: 1'b1};
            S_ON:        o = '{pu: 1'b1, en: 1'b1, rdy: 1'b1, busy: 1'b0};
            S_DISABLE:   o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0, busy: 1'b1};
            default:     o = '{pu: 1'b0, en: 1'b0, rdy: 1'b0, busy: 1'b0};
        endcase
        decode_state = o;
    endfunction

endpackage

// File: rtl/hsosc_pwr_seq_chk.sv
// Invariant checker for the HSOSC sequencer pins: enable only with power-up,
// ready only with enable, and enable never rising before power-up has been
// high for the full wait time.
module hsosc_pwr_seq_chk #(
    parameter int PU_WAIT_CYC = 1200
) (
    input logic clk,
    input logic rst,
    input logic clkhfpu,
    input logic clkhfen,
    input logic ready
);

    int   pu_age_q;
    logic en_prev_q;

    // Track how long CLKHFPU has been high and the previous CLKHFEN level
    always_ff @(posedge clk) begin
        if (rst) begin
            pu_age_q  <= '0;
            en_prev_q <= 1'b0;
        end else begin
            if (!clkhfpu) begin
                pu_age_q <= '0;
            end else if (pu_age_q < PU_WAIT_CYC) begin
                pu_age_q <= pu_age_q + 32'sd1;
            end else begin
                pu_age_q <= pu_age_q;
            end
            en_prev_q <= clkhfen;
        end
    end

    // Pin-ordering invariants, checked on every cycle out of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_en_needs_pu: assert (!clkhfen || clkhfpu)
                else $error("clkhfen high while clkhfpu low");
            a_rdy_needs_en: assert (!ready || clkhfen)
                else $error("ready high while clkhfen low");
            a_pu_wait: assert (!(clkhfen && !en_prev_q) || (pu_age_q >= PU_WAIT_CYC))
                else $error("clkhfen rose after only %0d power-up cycles", pu_age_q);
        end
    end

endmodule

// File: rtl/seq_timer.sv
// Loadable down-counter used to time power-sequencing phases. A load of
// N-1 makes zero assert N cycles after the loading edge's following edge
// sequence, i.e. the owning state sees zero on its N-th cycle.
module seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_q;

    // Next count: load wins, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with a registered zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/hsosc_pwr_seq.sv
// Power sequencer for the iCE40UP HSOSC: raises CLKHFPU, waits the
// power-up time with CLKHFEN low, enables, lets the clock settle, then
// reports ready. Shutdown drops CLKHFEN first and holds CLKHFPU for a
// guard time. Runs from an always-on clock, never from the HSOSC output.
module hsosc_pwr_seq
    import hsosc_seq_pkg::*;
#(
    parameter int PU_WAIT_CYC   = 1200,
    parameter int EN_SETTLE_CYC = 16,
    parameter int OFF_GUARD_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               clkhfpu,
    output logic               clkhfen,
    output logic               ready,
    output logic               busy,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = cnt_width(PU_WAIT_CYC, EN_SETTLE_CYC, OFF_GUARD_CYC);

    localparam logic [CNT_W-1:0] PU_LOAD  = CNT_W'(PU_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_GUARD_CYC - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    seq_out_t         out_q;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state and timer-load decisions; a dropped request outranks expiry
    always_comb begin
        state_d    = state_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_q)
            S_OFF: begin
                if (req) begin
                    state_d    = S_PU_WAIT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PU_LOAD;
                end else begin
                    state_d = S_OFF;
                end
            end
            S_PU_WAIT: begin
                // Enable never went high here, so no guard time is needed
                if (!req) begin
                    state_d = S_OFF;
                end else if (tmr_zero_s) begin
                    state_d    = S_EN_SETTLE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = EN_LOAD;
                end else begin
                    state_d = S_PU_WAIT;
                end
            end
            S_EN_SETTLE: begin
                if (!req) begin
                    state_d    = S_DISABLE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = OFF_LOAD;
                end else if (tmr_zero_s) begin
                    state_d = S_ON;
                end else begin
                    state_d = S_EN_SETTLE;
                end
            end
            S_ON: begin
                if (!req) begin
                    state_d    = S_DISABLE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = OFF_LOAD;
                end else begin
                    state_d = S_ON;
                end
            end
            S_DISABLE: begin
                // Request is ignored; a re-request restarts from OFF so the
                // full power-up wait is always honoured
                if (tmr_zero_s) begin
                    state_d = S_OFF;
                end else begin
                    state_d = S_DISABLE;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // State register with outputs decoded from the incoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= decode_state(state_d);
        end
    end

    assign clkhfpu = out_q.pu;
    assign clkhfen = out_q.en;
    assign ready   = out_q.rdy;
    assign busy    = out_q.busy;
    assign state_o = state_q;

endmodule

// File: tb/tb_hsosc_pwr_seq.sv
// Scoreboard bench for hsosc_pwr_seq. The driver applies req/rst each cycle,
// advances a timestamp-based reference model and pushes the expected outputs;
// a negedge monitor pops and compares, and also records pin edges so the
// directed scenarios can check absolute timing.
module tb_hsosc_pwr_seq;

    localparam int PU_W  = 8;
    localparam int EN_S  = 2;
    localparam int OFF_G = 3;

    typedef struct {
        int         edge_n;
        logic       pu;
        logic       en;
        logic       rdy;
        logic       busy;
        logic [2:0] st;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       req;
    logic       clkhfpu;
    logic       clkhfen;
    logic       ready;
    logic       busy;
    logic [2:0] state_o;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;
    int   edge_n;
    int   m_up;
    int   m_dn;
    int   pu_rise_e;
    int   pu_fall_e;
    int   en_rise_e;
    int   rdy_rise_e;
    logic pu_prev;
    logic en_prev;
    logic rdy_prev;

    hsosc_pwr_seq #(
        .PU_WAIT_CYC   (PU_W),
        .EN_SETTLE_CYC (EN_S),
        .OFF_GUARD_CYC (OFF_G)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .clkhfpu (clkhfpu),
        .clkhfen (clkhfen),
        .ready   (ready),
        .busy    (busy),
        .state_o (state_o)
    );

    hsosc_pwr_seq_chk #(
        .PU_WAIT_CYC (PU_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .clkhfpu (clkhfpu),
        .clkhfen (clkhfen),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, advance the model, push expectation.
    // Model: m_up = edge at which power-up began, m_dn = edge at which shutdown
    // began (-1 when inactive); phase follows from elapsed edges.
    task automatic cycle(input logic r, input logic q);
        exp_t x;
        int   e;
        rst = r;
        req = q;
        @(posedge clk);
        edge_n = edge_n + 1;
        if (r) begin
            m_up = -1;
            m_dn = -1;
        end else if (m_dn >= 0) begin
            if (edge_n - m_dn >= OFF_G) m_dn = -1;
        end else if (m_up >= 0) begin
            if (!q) begin
                e = edge_n - 1 - m_up;
                if (e >= PU_W) m_dn = edge_n;
                m_up = -1;
            end
        end else if (q) begin
            m_up = edge_n;
        end
        x.edge_n = edge_n;
        if (m_dn >= 0) begin
            x.pu = 1'b1; x.en = 1'b0; x.rdy = 1'b0; x.busy = 1'b1; x.st = 3'd4;
        end else if (m_up >= 0) begin
            e = edge_n - m_up;
            if (e < PU_W) begin
                x.pu = 1'b1; x.en = 1'b0; x.rdy = 1'b0; x.busy = 1'b1; x.st = 3'd1;
            end else if (e < PU_W + EN_S) begin
                x.pu = 1'b1; x.en = 1'b1; x.rdy = 1'b0; x.busy = 1'b1; x.st = 3'd2;
            end else begin
                x.pu = 1'b1; x.en = 1'b1; x.rdy = 1'b1; x.busy = 1'b0; x.st = 3'd3;
            end
        end else begin
            x.pu = 1'b0; x.en = 1'b0; x.rdy = 1'b0; x.busy = 1'b0; x.st = 3'd0;
        end
        sb_q.push_back(x);
        #1;
    endtask

    task automatic hold(input logic r, input logic q, input int n);
        for (int i = 0; i < n; i++) cycle(r, q);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks = n_checks + 1;
        if (got != want) $display("FAIL %s got %0d want %0d", name, got, want);
        else n_pass = n_pass + 1;
    endtask

    // Monitor: compare DUT outputs to the queued expectation and log pin edges
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            n_checks = n_checks + 1;
            if ({clkhfpu, clkhfen, ready, busy, state_o} !== {x.pu, x.en, x.rdy, x.busy, x.st}) begin
                $display("FAIL outputs@edge%0d got pu=%b en=%b rdy=%b busy=%b st=%0d want pu=%b en=%b rdy=%b busy=%b st=%0d",
                         x.edge_n, clkhfpu, clkhfen, ready, busy, state_o,
                         x.pu, x.en, x.rdy, x.busy, x.st);
            end else begin
                n_pass = n_pass + 1;
            end
            n_checks = n_checks + 1;
            if ((clkhfen && !clkhfpu) || (ready && !clkhfen)) begin
                $display("FAIL invariant@edge%0d got pu=%b en=%b rdy=%b want en->pu and rdy->en",
                         x.edge_n, clkhfpu, clkhfen, ready);
            end else begin
                n_pass = n_pass + 1;
            end
            if (clkhfpu && !pu_prev) pu_rise_e = x.edge_n;
            if (!clkhfpu && pu_prev) pu_fall_e = x.edge_n;
            if (clkhfen && !en_prev) en_rise_e = x.edge_n;
            if (ready && !rdy_prev) rdy_rise_e = x.edge_n;
            pu_prev  = clkhfpu;
            en_prev  = clkhfen;
            rdy_prev = ready;
        end
    end

    initial begin
        int e0;
        int len;
        logic q;
        n_checks = 0;  n_pass = 0;   edge_n = 0;
        m_up = -1;     m_dn = -1;
        pu_rise_e = -1; pu_fall_e = -1; en_rise_e = -1; rdy_rise_e = -1;
        pu_prev = 1'b0; en_prev = 1'b0; rdy_prev = 1'b0;
        rst = 1'b1;    req = 1'b0;

        // Reset, then idle
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 4);

        // Power-up
        cycle(1'b0, 1'b1);
        e0 = edge_n;
        hold(1'b0, 1'b1, 14);
        check_int("pu_up_edge",  pu_rise_e,  e0);
        check_int("en_up_edge",  en_rise_e,  e0 + PU_W);
        check_int("rdy_up_edge", rdy_rise_e, e0 + PU_W + EN_S);

        // Power-down from ON
        cycle(1'b0, 1'b0);
        e0 = edge_n;
        hold(1'b0, 1'b0, 6);
        check_int("pu_down_edge", pu_fall_e, e0 + OFF_G);

        // Abort in PU_WAIT
        en_rise_e = -1;
        hold(1'b0, 1'b1, 4);
        cycle(1'b0, 1'b0);
        e0 = edge_n;
        hold(1'b0, 1'b0, 5);
        check_int("abort_pu_fall", pu_fall_e, e0);
        check_int("abort_no_en",   en_rise_e, -1);

        // Abort in EN_SETTLE
        rdy_rise_e = -1;
        hold(1'b0, 1'b1, PU_W + 1);
        cycle(1'b0, 1'b0);
        e0 = edge_n;
        hold(1'b0, 1'b0, 6);
        check_int("settle_pu_fall", pu_fall_e, e0 + OFF_G);
        check_int("settle_no_rdy",  rdy_rise_e, -1);

        // Re-request during DISABLE
        hold(1'b0, 1'b1, 12);
        cycle(1'b0, 1'b0);
        e0 = edge_n;
        hold(1'b0, 1'b1, 16);
        check_int("rereq_pu_rise",  pu_rise_e,  e0 + OFF_G + 1);
        check_int("rereq_en_rise",  en_rise_e,  e0 + OFF_G + 1 + PU_W);
        check_int("rereq_rdy_rise", rdy_rise_e, e0 + OFF_G + 1 + PU_W + EN_S);
        hold(1'b0, 1'b0, 5);

        // Reset during PU_WAIT, then restart
        hold(1'b0, 1'b1, 5);
        cycle(1'b1, 1'b1);
        e0 = edge_n;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        hold(1'b0, 1'b1, 12);
        check_int("rst_pu_fall",    pu_fall_e, e0);
        check_int("rst_pu_restart", pu_rise_e, e0 + 2);
        hold(1'b0, 1'b0, 5);

        // Randomized request bursts with occasional resets
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, 14);
            q   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) cycle(($urandom_range(0, 59) == 0), q);
        end

        hold(1'b0, 1'b0, 2);
        @(negedge clk);
        #1;
        check_int("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
